control_sequencer: RTL

Fetch–decode–execute sequencer for the 16-bit accumulator machine. Owns the PC, MAR, MBR, IR and AC registers and a multi-cycle state machine. Drives the main memory port (registered read, one-cycle latency) and the combinational ALU. Sits between memory and ALU and issues every memory and ALU transaction.

---
 rtl/control_sequencer_if.sv | 22 ++
 rtl/control_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Memory port and ALU port of the accumulator machine, as seen by the sequencer.
// master = sequencer side, slave = memory/ALU side.
interface control_sequencer_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  modport master (
    output mem_addr, mem_wdata, mem_we, alu_op, alu_a, alu_b,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, alu_op, alu_a, alu_b,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch-decode-execute sequencer for the 16-bit accumulator machine.
// Define CONTROL_SEQUENCER_INDIRECT_EN to build ADDI/JUMPI; otherwise 0xB/0xC are NOPs.
module control_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  control_sequencer_if.master        bus,
  output logic [11:0]                o_pc,
  output logic [15:0]                o_ac,
  output logic [15:0]                o_ir,
  output logic                       o_halted,
  output logic                       o_retire
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_RD, S_EX, S_STORE, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;
  localparam logic [3:0] OP_ADDI  = 4'hB;
  localparam logic [3:0] OP_JUMPI = 4'hC;

  state_t             r_state, w_state_nxt;
  logic        [11:0] r_pc, w_pc_nxt;
  logic        [11:0] r_mar, w_mar_nxt;
  logic        [15:0] r_mbr, w_mbr_nxt;
  logic        [15:0] r_ir, w_ir_nxt;
  logic signed [15:0] r_ac, w_ac_nxt;
  logic        [3:0]  w_opc;
  logic               w_retire;
  logic               w_unused_mbr;

`ifdef CONTROL_SEQUENCER_INDIRECT_EN
  logic r_ind, w_ind_nxt;
  logic w_ind_pend;
  assign w_ind_pend = ((w_opc == OP_ADDI) || (w_opc == OP_JUMPI)) && !r_ind;
`endif

  // SKIPCOND: IR[11:10] selects AC<0, AC==0, AC>0 or never.
  function automatic logic f_skip(input logic [1:0] cond, input logic signed [15:0] ac);
    case (cond)
      2'b00:   f_skip = (ac < 0);
      2'b01:   f_skip = (ac == 0);
      2'b10:   f_skip = (ac > 0);
      default: f_skip = 1'b0;
    endcase
  endfunction

  assign w_opc = r_ir[15:12];
  // MBR mirrors the last operand read; nothing downstream consumes it.
  assign w_unused_mbr = ^r_mbr;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_mar_nxt   = r_mar;
    w_mbr_nxt   = r_mbr;
    w_ir_nxt    = r_ir;
    w_ac_nxt    = r_ac;
    w_retire    = 1'b0;
`ifdef CONTROL_SEQUENCER_INDIRECT_EN
    w_ind_nxt   = r_ind;
`endif
    case (r_state)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          w_pc_nxt    = RESET_PC;
          w_state_nxt = S_F0;
        end
      end
      S_F0: begin
        w_mar_nxt   = r_pc;
        w_state_nxt = S_F1;
      end
      S_F1: w_state_nxt = S_F2;
      S_F2: begin
        w_ir_nxt    = bus.mem_rdata;
        w_pc_nxt    = r_pc + 12'd1;
        w_state_nxt = S_DEC;
      end
      S_DEC: begin
        w_mar_nxt   = r_ir[11:0];
        w_state_nxt = S_F0;
        w_retire    = 1'b1;
        case (w_opc)
          OP_LOAD, OP_ADD, OP_SUBT, OP_AND, OP_OR: begin
            w_state_nxt = S_RD;
            w_retire    = 1'b0;
          end
`ifdef CONTROL_SEQUENCER_INDIRECT_EN
          OP_ADDI, OP_JUMPI: begin
            w_state_nxt = S_RD;
            w_retire    = 1'b0;
          end
`endif
          OP_STORE: begin
            w_state_nxt = S_STORE;
            w_retire    = 1'b0;
          end
          OP_HALT:  w_state_nxt = S_HALT;
          OP_SKIP:  if (f_skip(r_ir[11:10], r_ac)) w_pc_nxt = r_pc + 12'd1;
          OP_JUMP:  w_pc_nxt = r_ir[11:0];
          OP_CLEAR: w_ac_nxt = '0;
          default:  ;
        endcase
      end
      S_RD: w_state_nxt = S_EX;
      S_EX: begin
        w_mbr_nxt   = bus.mem_rdata;
        w_state_nxt = S_F0;
        w_retire    = 1'b1;
        case (w_opc)
          OP_LOAD:                          w_ac_nxt = bus.mem_rdata;
          OP_ADD, OP_SUBT, OP_AND, OP_OR:   w_ac_nxt = bus.alu_result;
`ifdef CONTROL_SEQUENCER_INDIRECT_EN
          OP_ADDI:                          w_ac_nxt = bus.alu_result;
          OP_JUMPI:                         w_pc_nxt = bus.mem_rdata[11:0];
`endif
          default: ;
        endcase
`ifdef CONTROL_SEQUENCER_INDIRECT_EN
        w_ind_nxt = 1'b0;
        // First pass of an indirect op only chases the pointer.
        if (w_ind_pend) begin
          w_ac_nxt    = r_ac;
          w_pc_nxt    = r_pc;
          w_mar_nxt   = bus.mem_rdata[11:0];
          w_ind_nxt   = 1'b1;
          w_state_nxt = S_RD;
          w_retire    = 1'b0;
        end
`endif
      end
      S_STORE: begin
        w_state_nxt = S_F0;
        w_retire    = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_mar   <= '0;
      r_mbr   <= '0;
      r_ir    <= '0;
      r_ac    <= '0;
`ifdef CONTROL_SEQUENCER_INDIRECT_EN
      r_ind   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_mar   <= w_mar_nxt;
      r_mbr   <= w_mbr_nxt;
      r_ir    <= w_ir_nxt;
      r_ac    <= w_ac_nxt;
`ifdef CONTROL_SEQUENCER_INDIRECT_EN
      r_ind   <= w_ind_nxt;
`endif
    end
  end

  always_comb begin
    bus.alu_op = 4'b0000;
    if (r_state == S_EX) begin
      case (w_opc)
        OP_SUBT: bus.alu_op = 4'b0001;
        OP_AND:  bus.alu_op = 4'b1000;
        OP_OR:   bus.alu_op = 4'b1001;
        default: bus.alu_op = 4'b0000;
      endcase
    end
  end

  assign bus.mem_addr  = {4'b0000, r_mar};
  assign bus.mem_wdata = r_ac;
  assign bus.mem_we    = (r_state == S_STORE);
  assign bus.alu_a     = r_ac;
  assign bus.alu_b     = bus.mem_rdata;

  assign o_pc     = r_pc;
  assign o_ac     = r_ac;
  assign o_ir     = r_ir;
  assign o_halted = (r_state == S_HALT);
  assign o_retire = w_retire;

endmodule
